arbiter: RTL and testbench
==========================

// Module: arbiter
// PURPOSE
//  16-channel round-robin arbiter multiplexing per-channel 16-bit word streams onto one 16-bit output
//  with a K-character flag (feeds the 8b/10b serial link encoder).
//  Sits between the channel data-processing blocks and the link transmitter.
//  Emits a comma (idle) K-word when no data is transferred, and a one-cycle trigger K-word on trigger.
// PARAMETERS
//  NCH        16        number of channels (req/ack width, data = NCH*W)
//  W          16        word width
//  IDLE_WORD  16'h50BC  idle/comma word (K28.5 in low byte), sent with kchar=1
//  TRIG_WORD  16'h007C  trigger word (K28.3 in low byte), sent with kchar=1
//  MAX_BURST  256       max words per grant (only with ARB_BURST_LIMIT_EN)
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  reset    in   1        synchronous, active-high reset
//  data     in   NCH*W    channel i word on data[W*i+W-1 : W*i]
//  req      in   NCH      channel i has words to send; held high for the whole block
//  ack      out  NCH      one-hot grant (registered); word i consumed at edge with ack[i]&req[i]
//  trigger  in   1        one-cycle pulse: insert TRIG_WORD
//  dout     out  W        output word (registered)
//  kchar    out  1        1 = dout is a K-word (idle/trigger), 0 = data
// BEHAVIOUR
//  - Reset: ack=0, dout=IDLE_WORD, kchar=1, state=IDLE, last-served pointer=NCH-1 (ch0 first).
//  - States IDLE, GRANT. IDLE: at edge with any req, pick first set req searching last+1..last+NCH
//    (mod NCH); ack[g]<=1, state<=GRANT, last<=g. No req: stay IDLE.
//  - GRANT: edge with ack[g]&req[g] -> dout<=data slice g, kchar<=0 (one-cycle latency).
//    Edge with req[g]=0 -> ack<=0, state<=IDLE; >=1 ack-low cycle between grants.
//  - Any edge with no word transferred: dout<=IDLE_WORD, kchar<=1.
//  - trigger high at edge: dout<=TRIG_WORD, kchar<=1, ack<=0 for next cycle (channel stalls, word
//    not consumed); grant kept, ack reasserted following cycle if req[g] still high. Trigger wins
//    over data; back-to-back triggers each produce a TRIG_WORD.
//  - Only one ack bit ever high; reqs on other channels ignored during GRANT.
//  - reset mid-burst: immediate return to reset values; channel must tolerate ack drop.
// CONFIGURATION
//  ARB_BURST_LIMIT_EN defined: word counter per grant; after MAX_BURST transfers ack<=0, state<=IDLE
//    even if req[g] high; channel g re-arbitrates round-robin (others get a turn first).
//  Not defined: grant held until req[g] falls (unbounded burst); counter not built.
// STRUCTURE
//  Package arb_pkg: NCH, W, IDLE_WORD, TRIG_WORD, state enum {IDLE,GRANT}.
//  Sub-module rr_pick: combinational rotate-priority encoder (req, last) -> (valid, index).
// TESTING
//  - Reset: reset high 3 cycles -> ack=0, dout=16'h50BC, kchar=1 throughout and after release.
//  - data[47:32]=16'h1234, req[2] high 25 cycles -> ack[2] high 25 cycles from 1 cycle after
//    first req edge; dout=16'h1234,kchar=0 for 24 cycles; idle word after; other ack bits 0.
//  - Repeat req[2] pulse (25 on / 40 off) x3 -> identical response each burst, idle gaps between.
//  - req[1],req[5],req[9] all held -> grants 1,5,9,1... after each drops req; one idle cycle between.
//  - trigger pulse during req[2] burst -> one cycle dout=16'h007C,kchar=1, ack[2] low that cycle,
//    no 16'h1234 word lost (total data words still equals req-high edges with ack).
//  - ARB_BURST_LIMIT_EN, MAX_BURST=4, req[2]&req[3] held -> 4 words ch2, gap, 4 words ch3, gap, ch2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the 16-channel round-robin link arbiter.
// The optional burst limit is enabled by defining ARB_BURST_LIMIT_EN.
package arb_pkg;
    localparam int NCH = 16;
    localparam int W = 16;
    localparam int LW = $clog2(NCH);
    localparam logic [W-1:0] IDLE_WORD = 16'h50BC;
    localparam logic [W-1:0] TRIG_WORD = 16'h007C;

    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational rotate-priority encoder: the first set req after 'last', wrapping around.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [LW-1:0]  last,
    output logic           valid,
    output logic [LW-1:0]  index
);
    logic [LW-1:0] cand;

    // Scan from farthest to nearest so the nearest candidate is assigned last.
    // Index wrap relies on NCH being a power of two.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = last + LW'(k);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end
endmodule

// File: rtl/arbiter.sv
// Round-robin arbiter merging 16 channel word streams onto one K-flagged link word.
// Define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST words.
module arbiter
    import arb_pkg::*;
`ifdef ARB_BURST_LIMIT_EN
#(
    parameter int MAX_BURST = 256
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH*W-1:0] data,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   ack,
    input  logic             trigger,
    output logic [W-1:0]     dout,
    output logic             kchar
);
    state_t         state_reg, state_next;
    logic [LW-1:0]  last_reg, last_next;
    logic [NCH-1:0] ack_reg, ack_next;
    logic [W-1:0]   dout_reg, dout_next;
    logic           kchar_reg, kchar_next;
    logic           pend_reg, pend_next;
    logic [W-1:0]   pend_word_reg, pend_word_next;

    logic [W-1:0]   words [NCH];
    logic           pick_valid;
    logic [LW-1:0]  pick_index;
    logic           gnt_req;
    logic           xfer;
    logic           burst_done;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_words
            assign words[gi] = data[W*gi +: W];
        end
    endgenerate

    rr_pick u_pick (
        .req   (req),
        .last  (last_reg),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign gnt_req = req[last_reg];
    assign xfer    = (state_reg == GRANT) && ack_reg[last_reg] && gnt_req;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt_reg, cnt_next;

    assign burst_done = xfer && (cnt_reg == CW'(MAX_BURST - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE)
            cnt_next = '0;
        else if (xfer)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`else
    assign burst_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_reg      <= LW'(NCH - 1);
            ack_reg       <= '0;
            dout_reg      <= IDLE_WORD;
            kchar_reg     <= 1'b1;
            pend_reg      <= 1'b0;
            pend_word_reg <= '0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            ack_reg       <= ack_next;
            dout_reg      <= dout_next;
            kchar_reg     <= kchar_next;
            pend_reg      <= pend_next;
            pend_word_reg <= pend_word_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid && !trigger) begin
                    state_next = GRANT;
                    last_next  = pick_index;
                end
            end
            GRANT: begin
                if (!gnt_req || burst_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A word accepted on a trigger edge is parked and sent on the following
    // stall cycle, so the trigger never costs the channel a word.
    always_comb begin
        ack_next       = '0;
        dout_next      = IDLE_WORD;
        kchar_next     = 1'b1;
        pend_next      = pend_reg;
        pend_word_next = pend_word_reg;

        if (trigger) begin
            dout_next = TRIG_WORD;
            if (xfer) begin
                pend_next      = 1'b1;
                pend_word_next = words[last_reg];
            end
        end else if (pend_reg) begin
            dout_next  = pend_word_reg;
            kchar_next = 1'b0;
            pend_next  = 1'b0;
        end else if (xfer) begin
            dout_next  = words[last_reg];
            kchar_next = 1'b0;
        end

        case (state_reg)
            IDLE:    if (pick_valid && !trigger) ack_next[pick_index] = 1'b1;
            GRANT:   if (gnt_req && !burst_done && !trigger) ack_next[last_reg] = 1'b1;
            default: ack_next = '0;
        endcase
    end

    assign ack   = ack_reg;
    assign dout  = dout_reg;
    assign kchar = kchar_reg;
endmodule

// File: tb/tb_arbiter.sv
// Scoreboard bench for the round-robin arbiter: channels push each consumed word,
// the link side pops and compares. Define ARB_BURST_LIMIT_EN to exercise MAX_BURST=4.
module tb_arbiter;
    localparam int NCH = 16;
    localparam int W = 16;
    localparam logic [15:0] IDLE_W = 16'h50BC;
    localparam logic [15:0] TRIG_W = 16'h007C;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH*W-1:0] data;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   ack;
    logic             trigger;
    logic [W-1:0]     dout;
    logic             kchar;

    always #5 clk = ~clk;

`ifdef ARB_BURST_LIMIT_EN
    arbiter #(.MAX_BURST(4)) dut (
`else
    arbiter dut (
`endif
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .req     (req),
        .ack     (ack),
        .trigger (trigger),
        .dout    (dout),
        .kchar   (kchar)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] sb [$];
    int grant_log [$];
    int run_log [$];
    int blk_left [NCH];
    int seq [NCH];
    int ack_cnt [NCH];
    int off_cnt [NCH];
    int data_words = 0;
    int xfers = 0;
    int trig_seen = 0;
    int run_len = 0;
    logic trig_prev = 1'b0;
    logic [NCH-1:0] prev_ack = '0;
    logic fixed_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int c);
        logic [3:0]  cn;
        logic [11:0] sn;
        cn = 4'(c);
        sn = 12'(seq[c]);
        if (fixed_mode && c == 2)
            return 16'h1234;
        return {cn, sn};
    endfunction

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        int idx = -1;
        for (int i = 0; i < NCH; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

    // One clock: inspect the result of the previous edge, then drive the next one.
    task automatic tick(input logic trg);
        logic [NCH-1:0] r;
        @(negedge clk);
        if (trig_prev) begin
            chk("trig_word", {15'd0, kchar, dout}, {15'd0, 1'b1, TRIG_W});
            chk("trig_ack", 32'(ack), 32'd0);
            trig_seen++;
        end else if (kchar) begin
            chk("idle_word", 32'(dout), 32'(IDLE_W));
        end else begin
            chk("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("data_word", 32'(dout), 32'(sb.pop_front()));
            data_words++;
        end
        chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        if (prev_ack != 0 && ack != 0) chk("ack_steady", 32'(ack), 32'(prev_ack));
        if (ack != 0 && prev_ack == 0) grant_log.push_back(onehot_idx(ack));
        if (ack != 0) run_len++;
        else if (prev_ack != 0) begin
            run_log.push_back(run_len);
            run_len = 0;
        end
        for (int c = 0; c < NCH; c++)
            if (ack[c]) ack_cnt[c]++;
        prev_ack = ack;

        for (int c = 0; c < NCH; c++) begin
            r[c] = (blk_left[c] != 0);
            data[W*c +: W] = word_of(c);
        end
        req = r;
        trigger = trg;
        trig_prev = trg;
        for (int c = 0; c < NCH; c++) begin
            if (ack[c] && r[c]) begin
                sb.push_back(word_of(c));
                seq[c]++;
                blk_left[c]--;
                xfers++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        trigger = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dout", {15'd0, kchar, dout}, {15'd0, 1'b1, IDLE_W});
        prev_ack = '0;
        trig_prev = 1'b0;
        run_len = 0;
        grant_log.delete();
        run_log.delete();
    endtask

    initial begin
        int exp_order [6] = '{1, 5, 9, 1, 5, 9};
        for (int c = 0; c < NCH; c++) begin
            blk_left[c] = 0;
            seq[c] = 0;
            ack_cnt[c] = 0;
            off_cnt[c] = 0;
        end
        reset = 1'b1;
        req = '0;
        trigger = 1'b0;
        data = '0;

        // Reset held three cycles, outputs checked during and after
        repeat (3) begin
            @(negedge clk);
            chk("reset_ack", 32'(ack), 32'd0);
            chk("reset_k", {15'd0, kchar, dout}, {15'd0, 1'b1, IDLE_W});
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset", {15'd0, kchar, dout}, {15'd0, 1'b1, IDLE_W});

`ifndef ARB_BURST_LIMIT_EN
        // Single 25-cycle request on channel 2 carrying 16'h1234
        fixed_mode = 1'b1;
        blk_left[2] = 24;
        ack_cnt[2] = 0;
        data_words = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            if (i == 0) chk("t2_ack_before", 32'(ack), 32'd0);
            if (i == 1) chk("t2_first_ack", 32'(ack), 32'h4);
        end
        chk("t2_ack_cycles", 32'(ack_cnt[2]), 32'd25);
        chk("t2_words", 32'(data_words), 32'd24);

        // Three identical bursts, 25 on / 40 off
        for (int b = 0; b < 3; b++) begin
            ack_cnt[2] = 0;
            data_words = 0;
            blk_left[2] = 24;
            repeat (65) tick(1'b0);
            chk("t3_ack_cycles", 32'(ack_cnt[2]), 32'd25);
            chk("t3_words", 32'(data_words), 32'd24);
        end
        fixed_mode = 1'b0;
`endif

        // Three channels held, each re-requesting shortly after its block ends
        do_reset();
        blk_left[1] = 3;
        blk_left[5] = 3;
        blk_left[9] = 3;
        for (int i = 0; i < 300 && grant_log.size() < 6; i++) begin
            tick(1'b0);
            foreach (exp_order[j]) begin
                if (j < 3 && blk_left[exp_order[j]] == 0) begin
                    off_cnt[exp_order[j]]++;
                    if (off_cnt[exp_order[j]] >= 3) begin
                        blk_left[exp_order[j]] = 3;
                        off_cnt[exp_order[j]] = 0;
                    end
                end
            end
        end
        repeat (60) tick(1'b0);
        chk("t4_grant_cnt", 32'(grant_log.size() >= 6), 32'd1);
        for (int j = 0; j < 6; j++)
            if (j < grant_log.size()) chk("t4_order", 32'(grant_log[j]), 32'(exp_order[j]));

        // Triggers mid-burst, including a back-to-back pair
        data_words = 0;
        xfers = 0;
        trig_seen = 0;
        blk_left[2] = 20;
        for (int i = 0; i < 45; i++)
            tick(i == 6 || i == 12 || i == 13);
        chk("t5_trig_count", 32'(trig_seen), 32'd3);
        chk("t5_no_loss", 32'(data_words), 32'(xfers));
        chk("t5_all_sent", 32'(xfers), 32'd20);

`ifdef ARB_BURST_LIMIT_EN
        // Burst cap of four alternates two held channels
        do_reset();
        blk_left[2] = 12;
        blk_left[3] = 12;
        repeat (80) tick(1'b0);
        chk("t6_grant_cnt", 32'(grant_log.size() >= 4), 32'd1);
        for (int j = 0; j < 4; j++) begin
            if (j < grant_log.size()) chk("t6_order", 32'(grant_log[j]), (j % 2 == 0) ? 32'd2 : 32'd3);
            if (j < run_log.size()) chk("t6_run_len", 32'(run_log[j]), 32'd4);
        end
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
